// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with per-register pending-write
// scoreboard, two prioritised writeback ports and optional write-to-read bypass.
// Ports:
//   clk, resetn                   clock, asynchronous active-low reset
//   rd_addr / rd_data / rd_busy   NRD combinational read ports + hazard flag
//   iss_valid / iss_addr          ID issue of an instruction writing iss_addr
//   iss_ready                     issue accepted (pending counter not saturated)
//   wb0_*, wb1_*                  writeback ports, wb1 wins on collision
//   flush                         clears every pending counter
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned SB_W   = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb0_we,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_we,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     flush
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned EXT_W = SB_W + 2;
    localparam logic [SB_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] rf      [NREG];
    logic [SB_W-1:0]   cnt     [NREG];
    logic [SB_W-1:0]   cnt_nxt [NREG];
    logic [1:0]        dec     [NREG];

    logic wb0_v;
    logic wb1_v;
    logic iss_fire;

    // Writes to r0 are discarded entirely, so they neither store nor decrement.
    assign wb0_v = wb0_we && (wb0_addr != '0);
    assign wb1_v = wb1_we && (wb1_addr != '0);

    // Number of writebacks retiring into each register this cycle.
    always_comb begin
        for (int a = 0; a < NREG; a++) begin
            dec[a] = {1'b0, wb0_v && (wb0_addr == ADDR_W'(a))}
                   + {1'b0, wb1_v && (wb1_addr == ADDR_W'(a))};
        end
    end

    // A saturated counter still accepts issue when a writeback frees a slot.
    assign iss_ready = (cnt[iss_addr] != CNT_MAX) || (dec[iss_addr] != 2'd0)
                     || (iss_addr == '0);
    assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);

    // Counter update, floored at zero so stale writebacks after flush are harmless.
    always_comb begin
        logic [EXT_W-1:0] sum;
        logic [EXT_W-1:0] sub;
        for (int a = 0; a < NREG; a++) begin
            sum = EXT_W'(cnt[a]) + EXT_W'(iss_fire && (iss_addr == ADDR_W'(a)));
            sub = EXT_W'(dec[a]);
            if (flush) begin
                cnt_nxt[a] = '0;
            end else if (sum > sub) begin
                cnt_nxt[a] = SB_W'(sum - sub);
            end else begin
                cnt_nxt[a] = '0;
            end
        end
    end

    // Pending counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int a = 0; a < NREG; a++) begin
                cnt[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NREG; a++) begin
                cnt[a] <= cnt_nxt[a];
            end
        end
    end

    // Register storage; wb1 is written last so it wins a collision.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int a = 0; a < NREG; a++) begin
                rf[a] <= '0;
            end
        end else begin
            if (wb0_v) begin
                rf[wb0_addr] <= wb0_data;
            end
            if (wb1_v) begin
                rf[wb1_addr] <= wb1_data;
            end
        end
    end

    // Read ports; r0 is never written so it always reads zero and is never busy.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;

        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*DATA_W +: DATA_W] = d;

        if (BYPASS != 0) begin : g_bp
            always_comb begin
                d = rf[a];
                if (wb0_v && (wb0_addr == a)) begin
                    d = wb0_data;
                end
                if (wb1_v && (wb1_addr == a)) begin
                    d = wb1_data;
                end
            end
            // Still busy only if writers remain beyond those retiring now.
            assign rd_busy[p] = (EXT_W'(cnt[a]) > EXT_W'(dec[a])) && !flush;
        end else begin : g_nbp
            assign d          = rf[a];
            assign rd_busy[p] = (cnt[a] != '0) && !flush;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two DUTs (bypass on/off) share stimulus; the stimulus
// process predicts outputs from an array model and queues them, a monitor on
// the falling edge pops and compares.
module tb_regfile_sb;

    logic        clk;
    logic        resetn;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_bp;
    logic [63:0] rd_data_nb;
    logic [1:0]  rd_busy_bp;
    logic [1:0]  rd_busy_nb;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready_bp;
    logic        iss_ready_nb;
    logic        wb0_we;
    logic [4:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb1_we;
    logic [4:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        flush;

    regfile_sb #(.BYPASS(1)) u_dut_bp (
        .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data_bp),
        .rd_busy(rd_busy_bp), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .iss_ready(iss_ready_bp), .wb0_we(wb0_we), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb1_we(wb1_we), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .flush(flush)
    );

    regfile_sb #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .iss_ready(iss_ready_nb), .wb0_we(wb0_we), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb1_we(wb1_we), .wb1_addr(wb1_addr),
        .wb1_data(wb1_data), .flush(flush)
    );

    typedef struct {
        int          id;
        logic [63:0] d_bp;
        logic [63:0] d_nb;
        logic [1:0]  b_bp;
        logic [1:0]  b_nb;
        logic        rdy;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          step_id = 0;
    logic [31:0] rf_m  [32];
    int          cnt_m [32];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h exp=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: compare whatever the stimulus side predicted for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data_bypass", e.id, rd_data_bp, e.d_bp);
                chk("rd_data_nobypass", e.id, rd_data_nb, e.d_nb);
                chk("rd_busy_bypass", e.id, 64'(rd_busy_bp), 64'(e.b_bp));
                chk("rd_busy_nobypass", e.id, 64'(rd_busy_nb), 64'(e.b_nb));
                chk("iss_ready_bypass", e.id, 64'(iss_ready_bp), 64'(e.rdy));
                chk("iss_ready_nobypass", e.id, 64'(iss_ready_nb), 64'(e.rdy));
            end
        end
    end

    function automatic int writes_to(input int a);
        int n = 0;
        if (a != 0 && wb0_we && int'(wb0_addr) == a) n++;
        if (a != 0 && wb1_we && int'(wb1_addr) == a) n++;
        return n;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   a;
        int   ia;
        e.id = step_id;
        for (int p = 0; p < 2; p++) begin
            a = (p == 0) ? int'(rd_addr[4:0]) : int'(rd_addr[9:5]);
            e.d_nb[p*32 +: 32] = rf_m[a];
            if (a != 0 && wb1_we && int'(wb1_addr) == a)      e.d_bp[p*32 +: 32] = wb1_data;
            else if (a != 0 && wb0_we && int'(wb0_addr) == a) e.d_bp[p*32 +: 32] = wb0_data;
            else                                               e.d_bp[p*32 +: 32] = rf_m[a];
            e.b_bp[p] = !flush && (cnt_m[a] > writes_to(a));
            e.b_nb[p] = !flush && (cnt_m[a] != 0);
        end
        ia = int'(iss_addr);
        e.rdy = (cnt_m[ia] != 3) || (writes_to(ia) != 0) || (ia == 0);
        return e;
    endfunction

    // One cycle: drive, predict, queue, clock, advance the model.
    task automatic step(input logic rst, input logic iv, input int ia,
                        input logic w0, input int a0, input logic [31:0] d0,
                        input logic w1, input int a1, input logic [31:0] d1,
                        input logic fl, input int r0, input int r1);
        exp_t e;
        int   nc;
        resetn    = !rst;
        iss_valid = iv;
        iss_addr  = 5'(ia);
        wb0_we    = w0;  wb0_addr = 5'(a0);  wb0_data = d0;
        wb1_we    = w1;  wb1_addr = 5'(a1);  wb1_data = d1;
        flush     = fl;
        rd_addr   = {5'(r1), 5'(r0)};
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_m[i]  = '0;
                cnt_m[i] = 0;
            end
        end
        e = predict();
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                nc = cnt_m[i] + ((iv && e.rdy && ia == i && i != 0) ? 1 : 0) - writes_to(i);
                cnt_m[i] = fl ? 0 : (nc < 0 ? 0 : nc);
            end
            if (w0 && a0 != 0) rf_m[a0] = d0;
            if (w1 && a1 != 0) rf_m[a1] = d1;
        end
        step_id++;
        #1;
    endtask

    task automatic idle(input int r0, input int r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic issue(input int ia);
        step(0, 1, ia, 0, 0, 0, 0, 0, 0, 0, ia, 0);
    endtask

    initial begin
        resetn = 1'b1; iss_valid = 0; iss_addr = 0; flush = 0; rd_addr = '0;
        wb0_we = 0; wb0_addr = 0; wb0_data = 0; wb1_we = 0; wb1_addr = 0; wb1_data = 0;
        #2;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        // Load r5, leave r6 pending, then reset between edges.
        step(0, 1, 6, 1, 5, 32'h1234, 0, 0, 0, 0, 5, 6);
        idle(5, 6);
        step(1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 5, 6);
        idle(5, 6);
        // r0 is hardwired: writes and issues are ignored.
        step(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        // Same-cycle bypass versus next-cycle visibility.
        step(0, 0, 0, 1, 3, 32'h0000_0BAD, 0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3, 32'h0000_CAFE, 0, 3, 3);
        idle(3, 0);
        // Collision on r7 with two writers in flight.
        issue(7);
        issue(7);
        step(0, 0, 0, 1, 7, 32'h11, 1, 7, 32'h22, 0, 7, 7);
        idle(7, 0);
        // Saturation on r9.
        issue(9); issue(9); issue(9);
        issue(9);
        step(0, 1, 9, 1, 9, 32'h9001, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 1, 9, 32'h9002, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 1, 9, 32'h9003, 0, 9, 0);
        step(0, 0, 0, 1, 9, 32'h9004, 0, 0, 0, 0, 9, 0);
        idle(9, 0);
        // Flush clears r4 pending writes; stale writeback does not underflow.
        issue(4); issue(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 4, 32'h4444, 0, 0, 0, 0, 4, 0);
        step(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 4, 4);
        idle(4, 4);
        // Randomised traffic concentrated on a few registers.
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 199) == 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 7), $urandom_range(0, 31));
        end
        idle(0, 0);
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
